// File: rtl/lcd_pkg.sv
// Shared mode encodings, colour constants and default 800x480 panel timing
// for the RGB-panel timing generator.
package lcd_pkg;

    typedef enum logic [1:0] {
        MODE_IMAGE   = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_SOLID   = 2'd2,
        MODE_CHECKER = 2'd3
    } lcd_mode_e;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 48;
    localparam int DEF_H_BP     = 40;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 13;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 29;

    localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
    localparam logic [23:0] RGB_BLACK = 24'h000000;

    // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][23:0] BAR_RGB = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

endpackage

// File: rtl/lcd_delay_line.sv
// Registered shift line with synchronous clear; DEPTH of zero degenerates
// to a wire so the pixel source latency can be zero.
module lcd_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_pipe
            logic [W-1:0] pipe [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= d;
                    for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign q = pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/lcd_timing_gen.sv
// RGB-panel timing generator: sync/DE generation, image-window reads from a
// fixed-latency pixel source, and test patterns re-aligned to the returned data.
module lcd_timing_gen
    import lcd_pkg::*;
#(
    parameter int          H_ACTIVE = DEF_H_ACTIVE,
    parameter int          H_FP     = DEF_H_FP,
    parameter int          H_SYNC   = DEF_H_SYNC,
    parameter int          H_BP     = DEF_H_BP,
    parameter int          V_ACTIVE = DEF_V_ACTIVE,
    parameter int          V_FP     = DEF_V_FP,
    parameter int          V_SYNC   = DEF_V_SYNC,
    parameter int          V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter bit          DE_POL   = 1'b1,
    parameter int          IMG_X    = 0,
    parameter int          IMG_Y    = 0,
    parameter int          IMG_W    = DEF_H_ACTIVE,
    parameter int          IMG_H    = DEF_V_ACTIVE,
    parameter int          RD_LAT   = 1,
    parameter int          CW       = 11,
    parameter int          AW       = 19,
    parameter logic [23:0] BG_RGB   = 24'h000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [1:0]    mode,
    input  logic [23:0]   img_data,
    output logic          img_ack,
    output logic [AW-1:0] img_addr,
    output logic [CW-1:0] hsync_cnt,
    output logic [CW-1:0] vsync_cnt,
    output logic          frame_start,
    output logic          lcd_hsync,
    output logic          lcd_vsync,
    output logic          lcd_de,
    output logic [7:0]    lcd_r,
    output logic [7:0]    lcd_g,
    output logic [7:0]    lcd_b,
    output logic          lcd_pwm
);

    localparam logic [CW-1:0] H_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW:0]   IMG_X_C = (CW+1)'(IMG_X);
    localparam logic [CW:0]   IMG_Y_C = (CW+1)'(IMG_Y);
    localparam logic [CW-1:0] IMG_W_C = CW'(IMG_W);
    localparam logic [CW-1:0] IMG_H_C = CW'(IMG_H);
    localparam logic [CW+2:0] BAR_DIV = (CW+3)'(H_ACTIVE);
    localparam int            DW      = 7 + CW;

    logic [CW-1:0] h_cnt, v_cnt;
    logic [AW-1:0] addr_q;
    logic          en_q;
    lcd_mode_e     mode_q;
    logic          h_last, v_last, start_next;
    logic          hs_raw, vs_raw, de_raw, win_raw;
    logic [CW:0]   h_off, v_off;

    assign h_last     = (h_cnt == H_LAST);
    assign v_last     = (v_cnt == V_LAST);
    // Next cycle is h=v=0 of a running frame: first cycle after enable, or a frame wrap.
    assign start_next = !en_q || (h_last && v_last);

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            h_cnt  <= '0;
            v_cnt  <= '0;
            addr_q <= '0;
            mode_q <= MODE_IMAGE;
        end else begin
            if (en_q) begin
                if (h_last) begin
                    h_cnt <= '0;
                    v_cnt <= v_last ? '0 : v_cnt + CW'(1);
                end else begin
                    h_cnt <= h_cnt + CW'(1);
                end
            end
            if (start_next) begin
                mode_q <= lcd_mode_e'(mode);
                addr_q <= '0;
            end else if (img_ack) begin
                addr_q <= addr_q + AW'(1);
            end
        end
        en_q <= rst ? 1'b0 : enable;
    end

    // The borrow bit of the offset doubles as the h >= IMG_X guard.
    assign h_off   = {1'b0, h_cnt} - IMG_X_C;
    assign v_off   = {1'b0, v_cnt} - IMG_Y_C;
    assign hs_raw  = en_q && (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_raw  = en_q && (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign de_raw  = en_q && (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign win_raw = de_raw && !h_off[CW] && (h_off[CW-1:0] < IMG_W_C)
                            && !v_off[CW] && (v_off[CW-1:0] < IMG_H_C);

    assign img_ack     = win_raw && (mode_q == MODE_IMAGE);
    assign img_addr    = addr_q;
    assign hsync_cnt   = h_cnt;
    assign vsync_cnt   = v_cnt;
    assign frame_start = en_q && (h_cnt == '0) && (v_cnt == '0);
    assign lcd_pwm     = en_q;

    logic [DW-1:0] stage_d, stage_q;
    logic          hs_d, vs_d, de_d, win_d, v4_d;
    logic [1:0]    mode_d;
    logic [CW-1:0] h_d;
    logic [2:0]    bar_idx;
    logic [23:0]   pix;

    // Only bit 4 of v is needed downstream (checker block row).
    assign stage_d = {hs_raw, vs_raw, de_raw, win_raw, mode_q, h_cnt, v_cnt[4]};

    lcd_delay_line #(.W(DW), .DEPTH(RD_LAT)) u_delay (
        .clk (clk),
        .rst (rst),
        .d   (stage_d),
        .q   (stage_q)
    );

    assign {hs_d, vs_d, de_d, win_d, mode_d, h_d, v4_d} = stage_q;
    assign bar_idx = 3'({h_d, 3'b000} / BAR_DIV);

    always_comb begin
        pix = '0;
        if (de_d) begin
            case (lcd_mode_e'(mode_d))
                MODE_IMAGE:   pix = win_d ? img_data : BG_RGB;
                MODE_BARS:    pix = BAR_RGB[bar_idx];
                MODE_SOLID:   pix = BG_RGB;
                MODE_CHECKER: pix = (h_d[4] ^ v4_d) ? RGB_WHITE : RGB_BLACK;
                default:      pix = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lcd_hsync               <= !HS_POL;
            lcd_vsync               <= !VS_POL;
            lcd_de                  <= !DE_POL;
            {lcd_r, lcd_g, lcd_b}   <= '0;
        end else begin
            lcd_hsync               <= hs_d ? HS_POL : !HS_POL;
            lcd_vsync               <= vs_d ? VS_POL : !VS_POL;
            lcd_de                  <= de_d ? DE_POL : !DE_POL;
            {lcd_r, lcd_g, lcd_b}   <= pix;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a 14x7 toy raster, with RD_LAT=1 and
// RD_LAT=3 instances driven from the same stimulus.
module tb_lcd_timing_gen;
    import lcd_pkg::*;

    localparam logic [23:0] BG = 24'h102030;

    logic        clk = 1'b0;
    logic        rst, enable;
    logic [1:0]  mode;
    logic [23:0] img_data, img_data3;
    logic        img_ack, img_ack3;
    logic [7:0]  img_addr, img_addr3;
    logic [10:0] h, v, h3, v3;
    logic        fs, fs3, hs, vs, de, hs3, vs3, de3, pwm, pwm3;
    logic [7:0]  r, g, b, r3, g3, b3;
    logic [23:0] rgb, rgb3;
    logic [23:0] s3 [3];

    int checks = 0;
    int errors = 0;
    int acks, des;

    assign rgb  = {r, g, b};
    assign rgb3 = {r3, g3, b3};

    always #5 clk = ~clk;

    // Pixel sources echo addr*3 with one and three clocks of latency.
    always @(posedge clk) begin
        img_data <= 24'(img_addr) * 24'd3;
        s3[0]    <= 24'(img_addr3) * 24'd3;
        s3[1]    <= s3[0];
        s3[2]    <= s3[1];
    end
    assign img_data3 = s3[2];

    lcd_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .IMG_X(2), .IMG_Y(1), .IMG_W(4), .IMG_H(2),
        .RD_LAT(1), .CW(11), .AW(8), .BG_RGB(BG)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .img_data(img_data),
        .img_ack(img_ack), .img_addr(img_addr), .hsync_cnt(h), .vsync_cnt(v),
        .frame_start(fs), .lcd_hsync(hs), .lcd_vsync(vs), .lcd_de(de),
        .lcd_r(r), .lcd_g(g), .lcd_b(b), .lcd_pwm(pwm)
    );

    lcd_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .IMG_X(2), .IMG_Y(1), .IMG_W(4), .IMG_H(2),
        .RD_LAT(3), .CW(11), .AW(8), .BG_RGB(BG)
    ) dut3 (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .img_data(img_data3),
        .img_ack(img_ack3), .img_addr(img_addr3), .hsync_cnt(h3), .vsync_cnt(v3),
        .frame_start(fs3), .lcd_hsync(hs3), .lcd_vsync(vs3), .lcd_de(de3),
        .lcd_r(r3), .lcd_g(g3), .lcd_b(b3), .lcd_pwm(pwm3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_h"},    32'(h), 0);
        chk({tag, "_v"},    32'(v), 0);
        chk({tag, "_addr"}, 32'(img_addr), 0);
        chk({tag, "_ack"},  32'(img_ack), 0);
        chk({tag, "_fs"},   32'(fs), 0);
        chk({tag, "_hs"},   32'(hs), 1);
        chk({tag, "_vs"},   32'(vs), 1);
        chk({tag, "_de"},   32'(de), 0);
        chk({tag, "_rgb"},  32'(rgb), 0);
        chk({tag, "_pwm"},  32'(pwm), 0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mode = MODE_IMAGE;
        repeat (3) @(negedge clk);
        chk_reset("init");

        rst = 1'b0; enable = 1'b1;
        @(negedge clk);

        // Frame 1: IMAGE; mode switched to BARS early in the frame.
        acks = 0; des = 0;
        for (int c = 0; c < 98; c++) begin
            if (img_ack) begin chk("f1_ack_addr", 32'(img_addr), 32'(acks)); acks++; end
            if (de) des++;
            case (c)
                0:  begin chk("f1_fs", 32'(fs), 1); chk("f1_h0", 32'(h), 0);
                          chk("f1_v0", 32'(v), 0); chk("f1_pwm", 32'(pwm), 1);
                          chk("f1_de_c0", 32'(de), 0); end
                1:  chk("f1_fs_c1", 32'(fs), 0);
                2:  begin chk("f1_de_c2", 32'(de), 1); chk("f1_bg_c2", 32'(rgb), 32'(BG));
                          chk("l3_de_c2", 32'(de3), 0); end
                3:  chk("l3_de_c3", 32'(de3), 0);
                4:  chk("l3_de_c4", 32'(de3), 1);
                5:  mode = MODE_BARS;
                9:  chk("f1_de_c9", 32'(de), 1);
                10: begin chk("f1_de_c10", 32'(de), 0); chk("f1_rgb_c10", 32'(rgb), 0); end
                11: chk("f1_hs_c11", 32'(hs), 1);
                12: chk("f1_hs_c12", 32'(hs), 0);
                13: begin chk("f1_hs_c13", 32'(hs), 0); chk("l3_hs_c13", 32'(hs3), 1); end
                14: begin chk("f1_hs_c14", 32'(hs), 1); chk("l3_hs_c14", 32'(hs3), 0); end
                15: chk("f1_ack_c15", 32'(img_ack), 0);
                16: begin chk("f1_ack_c16", 32'(img_ack), 1); chk("f1_bg_c16", 32'(rgb), 32'(BG)); end
                19: chk("f1_pix1", 32'(rgb), 32'h000003);
                20: chk("f1_ack_c20", 32'(img_ack), 0);
                21: chk("l3_pix1", 32'(rgb3), 32'h000003);
                35: chk("f1_pix7", 32'(rgb), 32'h000015);
                37: chk("l3_pix7", 32'(rgb3), 32'h000015);
                71: chk("f1_vs_c71", 32'(vs), 1);
                72: chk("f1_vs_c72", 32'(vs), 0);
                85: chk("f1_vs_c85", 32'(vs), 0);
                86: chk("f1_vs_c86", 32'(vs), 1);
                97: begin chk("f1_h97", 32'(h), 13); chk("f1_v97", 32'(v), 6);
                          chk("f1_addr_end", 32'(img_addr), 8); end
                default: ;
            endcase
            @(negedge clk);
        end
        chk("f1_acks", 32'(acks), 8);
        chk("f1_de_clks", 32'(des), 32);

        // Frame 2: BARS; request CHECKER for the next frame.
        acks = 0;
        for (int c = 0; c < 98; c++) begin
            if (img_ack) acks++;
            case (c)
                0: begin chk("f2_fs", 32'(fs), 1); chk("f2_addr0", 32'(img_addr), 0); end
                2: begin chk("f2_bar0", 32'(rgb), 32'hFFFFFF); chk("f2_de", 32'(de), 1); end
                3: chk("f2_bar1", 32'(rgb), 32'hFFFF00);
                5: begin chk("f2_bar3", 32'(rgb), 32'h00FF00); mode = MODE_CHECKER; end
                6: chk("f2_bar4", 32'(rgb), 32'hFF00FF);
                9: begin chk("f2_bar7", 32'(rgb), 32'h000000); chk("f2_de9", 32'(de), 1); end
                default: ;
            endcase
            @(negedge clk);
        end
        chk("f2_acks", 32'(acks), 0);

        // Frame 3: CHECKER (all black on this small raster); request SOLID.
        for (int c = 0; c < 98; c++) begin
            if (c == 2) begin chk("f3_chk_de", 32'(de), 1); chk("f3_chk_rgb", 32'(rgb), 0); end
            if (c == 5) mode = MODE_SOLID;
            @(negedge clk);
        end

        // Frame 4: SOLID; request IMAGE.
        acks = 0;
        for (int c = 0; c < 98; c++) begin
            if (img_ack) acks++;
            if (c == 2)  chk("f4_solid_c2", 32'(rgb), 32'(BG));
            if (c == 19) chk("f4_solid_c19", 32'(rgb), 32'(BG));
            if (c == 5)  mode = MODE_IMAGE;
            @(negedge clk);
        end
        chk("f4_acks", 32'(acks), 0);

        // Frame 5: IMAGE, enable dropped at h=5, v=2.
        for (int c = 0; c < 33; c++) begin
            if (c == 19) chk("f5_pix1", 32'(rgb), 32'h000003);
            @(negedge clk);
        end
        chk("f5_h33", 32'(h), 5);
        chk("f5_v33", 32'(v), 2);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_h", 32'(h), 0);
        chk("dis_v", 32'(v), 0);
        chk("dis_pwm", 32'(pwm), 0);
        chk("dis_ack", 32'(img_ack), 0);
        chk("dis_addr", 32'(img_addr), 0);
        chk("dis_fs", 32'(fs), 0);
        chk("dis_de_flush0", 32'(de), 1);
        @(negedge clk);
        chk("dis_de_flush1", 32'(de), 1);
        chk("dis_pix7", 32'(rgb), 32'h000015);
        @(negedge clk);
        chk("dis_de_idle", 32'(de), 0);
        chk("dis_rgb_idle", 32'(rgb), 0);
        chk("dis_hs_idle", 32'(hs), 1);
        enable = 1'b1;
        @(negedge clk);
        chk("reen_fs", 32'(fs), 1);
        chk("reen_h", 32'(h), 0);

        // Reset pulse mid-line at h=6, v=1.
        repeat (20) @(negedge clk);
        chk("pre_rst_addr", 32'(img_addr), 4);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("midrst");
        rst = 1'b0;
        @(negedge clk);
        chk("rst_fs", 32'(fs), 1);
        repeat (16) @(negedge clk);
        chk("rst_ack", 32'(img_ack), 1);
        chk("rst_addr", 32'(img_addr), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
